// File: rtl/seq_det_arbiter_if.sv
// Requester-side bundle for seq_det_arbiter: two request/data pairs in,
// one-hot grant plus detector status and completion results out.
interface seq_det_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) ();
    logic [1:0]       req;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [1:0]       gnt;
    logic             busy;
    logic             detector;
    logic             done;
    logic             done_id;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output req, data0, data1,
        input  gnt, busy, detector, done, done_id, match_cnt
    );

    modport slave (
        input  req, data0, data1,
        output gnt, busy, detector, done, done_id, match_cnt
    );
endinterface

// File: rtl/seq_det_arbiter.sv
// Round-robin arbiter feeding one serial Moore pattern detector from two word requesters.
// Optional macro SEQ_ARB_OVERLAP_EN selects overlapping detection (default: non-overlapping).
module seq_det_arbiter #(
    parameter int               WIDTH   = 8,
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
    parameter int               CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    seq_det_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    localparam int BC_W = $clog2(WIDTH + 1);
    localparam int HC_W = $clog2(PAT_W + 1);

    logic [1:0]       state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [BC_W-1:0]  bitcnt_q;
    logic [PAT_W-1:0] window_q;
    logic [HC_W-1:0]  hist_q;
    logic [CNT_W-1:0] cnt_q;
    logic             id_q;
    logic             last_q;
    logic             busy_q;
    logic             det_q;
    logic             done_q;

    logic [1:0]       grant_s;
    logic [WIDTH-1:0] word_s;
    logic             idle_s;
    logic             in_bit_s;
    logic [PAT_W-1:0] win_base_s;
    logic [PAT_W:0]   win_ext_s;
    logic [PAT_W-1:0] window_d;
    logic [HC_W-1:0]  hist_base_s;
    logic [HC_W-1:0]  hist_inc_s;
    logic [HC_W-1:0]  hist_d;
    logic [CNT_W-1:0] cnt_base_s;
    logic [CNT_W-1:0] cnt_d;
    logic             match_s;

    // Grant decode: only in IDLE and never while reset is held.
    always_comb begin
        grant_s = 2'b00;
        if (!rst && (state_q == S_IDLE)) begin
            case (bus.req)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = last_q ? 2'b01 : 2'b10;
                default: grant_s = 2'b00;
            endcase
        end else begin
            grant_s = 2'b00;
        end
    end

    // Next detector step; in IDLE the granted word's MSB enters a cleared detector.
    always_comb begin
        idle_s = (state_q == S_IDLE);
        if (grant_s[1]) begin
            word_s = bus.data1;
        end else begin
            word_s = bus.data0;
        end
        if (idle_s) begin
            in_bit_s    = word_s[WIDTH-1];
            win_base_s  = {PAT_W{1'b0}};
            hist_base_s = {HC_W{1'b0}};
            cnt_base_s  = {CNT_W{1'b0}};
        end else begin
            in_bit_s    = shreg_q[WIDTH-1];
            win_base_s  = window_q;
            hist_base_s = hist_q;
            cnt_base_s  = cnt_q;
        end
        win_ext_s = {win_base_s, in_bit_s};
        window_d  = win_ext_s[PAT_W-1:0];
        if (hist_base_s == HC_W'(PAT_W)) begin
            hist_inc_s = hist_base_s;
        end else begin
            hist_inc_s = hist_base_s + HC_W'(1);
        end
        match_s = (hist_inc_s == HC_W'(PAT_W)) && (window_d == PATTERN);
`ifdef SEQ_ARB_OVERLAP_EN
        hist_d = hist_inc_s;
`else
        if (match_s) begin
            hist_d = {HC_W{1'b0}};
        end else begin
            hist_d = hist_inc_s;
        end
`endif
        if (match_s && (cnt_base_s != {CNT_W{1'b1}})) begin
            cnt_d = cnt_base_s + CNT_W'(1);
        end else begin
            cnt_d = cnt_base_s;
        end
    end

    // Controller FSM, shift register and detector state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shreg_q  <= {WIDTH{1'b0}};
            bitcnt_q <= {BC_W{1'b0}};
            window_q <= {PAT_W{1'b0}};
            hist_q   <= {HC_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            id_q     <= 1'b0;
            last_q   <= 1'b1;
            busy_q   <= 1'b0;
            det_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (grant_s != 2'b00) begin
                        state_q  <= S_SHIFT;
                        shreg_q  <= word_s << 1;
                        bitcnt_q <= BC_W'(1);
                        window_q <= window_d;
                        hist_q   <= hist_d;
                        cnt_q    <= cnt_d;
                        det_q    <= match_s;
                        id_q     <= grant_s[1];
                        last_q   <= grant_s[1];
                        busy_q   <= 1'b1;
                    end else begin
                        det_q <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (bitcnt_q < BC_W'(WIDTH)) begin
                        shreg_q  <= shreg_q << 1;
                        bitcnt_q <= bitcnt_q + BC_W'(1);
                        window_q <= window_d;
                        hist_q   <= hist_d;
                        cnt_q    <= cnt_d;
                        det_q    <= match_s;
                    end else begin
                        state_q <= S_REPORT;
                        det_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_REPORT: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    det_q   <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = grant_s;
    assign bus.busy      = busy_q;
    assign bus.detector  = det_q;
    assign bus.done      = done_q;
    assign bus.done_id   = id_q;
    assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_seq_det_arbiter.sv
// Scoreboard bench for seq_det_arbiter: stimulus queues expected word results,
// a negedge monitor tracks each granted word and checks it when done appears.
module tb_seq_det_arbiter;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

`ifdef SEQ_ARB_OVERLAP_EN
    localparam logic [3:0]  C92 = 4'd2;
    localparam logic [15:0] M92 = 16'h0090;
`else
    localparam logic [3:0]  C92 = 4'd1;
    localparam logic [15:0] M92 = 16'h0010;
`endif

    typedef struct {
        logic [1:0]  gnt;
        logic        id;
        logic [3:0]  cnt;
        logic [15:0] mask;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   cycle;
    exp_t exp_q[$];

    seq_det_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    seq_det_arbiter #(.WIDTH(WIDTH), .PAT_W(4), .PATTERN(4'b1001), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] g, input logic id, input logic [3:0] c,
                                input logic [15:0] m);
        exp_t e;
        e.gnt = g; e.id = id; e.cnt = c; e.mask = m;
        return e;
    endfunction

    // Monitor: follows the word from its grant to its done and scores it.
    bit          tracking;
    int          mcyc;
    logic [15:0] mmask;
    logic [1:0]  mgnt;
    bit          busy_ok;
    always @(negedge clk) begin
        if (rst) begin
            tracking = 1'b0;
        end else begin
            if (tracking) begin
                mcyc++;
                if (bus.detector) mmask[mcyc] = 1'b1;
                if (!bus.busy) busy_ok = 1'b0;
                if (bus.done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("gnt", int'(mgnt), int'(e.gnt));
                        chk("done_id", int'(bus.done_id), int'(e.id));
                        chk("match_cnt", int'(bus.match_cnt), int'(e.cnt));
                        chk("detector_cycles", int'(mmask), int'(e.mask));
                        chk("done_cycle", mcyc, WIDTH + 1);
                        chk("busy_window", int'(busy_ok), 1);
                    end
                    tracking = 1'b0;
                end else if (mcyc > 20) begin
                    chk("done_timeout", 0, 1);
                    tracking = 1'b0;
                end
            end else if (bus.detector || bus.done) begin
                chk("stray_output", 1, 0);
            end
            if (bus.gnt != 2'b00) begin
                chk("busy_in_gnt_cycle", int'(bus.busy), 0);
                tracking = 1'b1;
                mcyc     = 0;
                mmask    = 16'h0000;
                mgnt     = bus.gnt;
                busy_ok  = 1'b1;
            end
        end
    end

    task automatic wait_gnt(output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.gnt != 2'b00) begin
                g = bus.gnt;
                return;
            end
        end
        chk("gnt_timeout", 0, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) return;
        end
        chk("done_timeout_stim", 0, 1);
    endtask

    task automatic do_word(input logic [1:0] r, input logic [7:0] d0, input logic [7:0] d1,
                           input exp_t e);
        logic [1:0] g;
        @(posedge clk); #1;
        exp_q.push_back(e);
        bus.req = r; bus.data0 = d0; bus.data1 = d1;
        wait_gnt(g);
        @(posedge clk); #1;
        bus.req = 2'b00;
        wait_done();
    endtask

    initial begin
        logic [1:0] g;
        int         gc [3];
        vectors = 0; miscompares = 0; cycle = 0;
        rst = 1'b1;
        bus.req = 2'b11; bus.data0 = 8'b1001_1001; bus.data1 = 8'b1001_0010;
        repeat (3) @(negedge clk);
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_detector", int'(bus.detector), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_done_id", int'(bus.done_id), 0);
        chk("rst_match_cnt", int'(bus.match_cnt), 0);

        @(posedge clk); #1;
        exp_q.push_back(mk(2'b01, 1'b0, 4'd2, 16'h0110));
        rst = 1'b0;
        @(negedge clk);
        chk("first_gnt_after_rst", int'(bus.gnt), 1);
        @(posedge clk); #1;
        bus.req = 2'b00;
        wait_done();

        do_word(2'b01, 8'b1001_1001, 8'h00, mk(2'b01, 1'b0, 4'd2, 16'h0110));
        do_word(2'b10, 8'h00, 8'b1001_0010, mk(2'b10, 1'b1, C92, M92));

        // Continuous contention: grants alternate at the full word rate.
        @(posedge clk); #1;
        exp_q.push_back(mk(2'b01, 1'b0, 4'd2, 16'h0110));
        exp_q.push_back(mk(2'b10, 1'b1, C92, M92));
        exp_q.push_back(mk(2'b01, 1'b0, 4'd2, 16'h0110));
        bus.req = 2'b11; bus.data0 = 8'b1001_1001; bus.data1 = 8'b1001_0010;
        for (int i = 0; i < 3; i++) begin
            wait_gnt(g);
            gc[i] = cycle;
            if (i > 0) chk("gnt_spacing", gc[i] - gc[i-1], WIDTH + 2);
        end
        @(posedge clk); #1;
        bus.req = 2'b00;
        wait_done();

        // Reset in cycle 4 of a word aborts it.
        @(posedge clk); #1;
        bus.req = 2'b01; bus.data0 = 8'b1001_1001;
        wait_gnt(g);
        @(posedge clk); #1;
        bus.req = 2'b00;
        repeat (4) @(negedge clk);
        chk("pre_abort_detector", int'(bus.detector), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_detector", int'(bus.detector), 0);
        chk("abort_done", int'(bus.done), 0);
        @(posedge clk); #1;
        exp_q.push_back(mk(2'b01, 1'b0, 4'd0, 16'h0000));
        exp_q.push_back(mk(2'b10, 1'b1, 4'd0, 16'h0000));
        bus.req = 2'b11; bus.data0 = 8'h00; bus.data1 = 8'hFF;
        rst = 1'b0;
        wait_gnt(g);
        chk("post_rst_first_gnt", int'(g), 1);
        @(posedge clk); #1;
        bus.req = 2'b10;
        wait_gnt(g);
        chk("post_rst_second_gnt", int'(g), 2);
        @(posedge clk); #1;
        bus.req = 2'b00;
        wait_done();

        do_word(2'b01, 8'h00, 8'h00, mk(2'b01, 1'b0, 4'd0, 16'h0000));
        do_word(2'b01, 8'hFF, 8'h00, mk(2'b01, 1'b0, 4'd0, 16'h0000));

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seq_det_arbiter.md
# seq_det_arbiter

Round-robin controller that shares one serial Moore pattern detector between two parallel-word requesters. A granted word is serialised MSB-first into the detector, which runs non-overlapping detection of a fixed pattern. Matches are counted and the count is returned to the requester with a one-cycle completion pulse. The block sits in front of the sequence-detector datapath so that several producers can use one detector.

## Interface
- `WIDTH`, 8: bits per word; must be ≥ `PAT_W`.
- `PAT_W`, 4: pattern length in bits.
- `PATTERN`, 4'b1001: pattern matched, compared MSB-first.
- `CNT_W`, $clog2(WIDTH+1): width of the match count.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  2  request, one bit per requester; held high until granted.
- `data0`  in  WIDTH  word from requester 0; stable while `req[0]` is high.
- `data1`  in  WIDTH  word from requester 1; stable while `req[1]` is high.
- `gnt`  out  2  one-hot accept pulse, one cycle long; the word is sampled on the clock edge that ends this cycle.
- `busy`  out  1  high from the cycle after `gnt` through the `done` cycle.
- `detector`  out  1  registered Moore detector output; high for one cycle after the bit that completes a match.
- `done`  out  1  one-cycle completion pulse.
- `done_id`  out  1  requester served; valid while `done` is high.
- `match_cnt`  out  CNT_W  number of matches in the word; valid while `done` is high.

## Operation
- FSM states: IDLE, SHIFT, REPORT.
- IDLE → SHIFT when `req` is non-zero.
  - `gnt` is combinational in IDLE.
  - The granted word is loaded into the shift register.
  - The bit counter, match counter, window and history counter are cleared.
- SHIFT: one bit per cycle, MSB first, for exactly WIDTH cycles, then → REPORT.
- REPORT: `done`=1, `done_id` and `match_cnt` are driven for one cycle, then → IDLE.
- Arbitration uses a last-grant pointer.
  - Single request: that requester is granted.
  - Both requesting: grant the requester not granted last.
  - The pointer resets to 1, so requester 0 wins the first contention.
  - The pointer updates only on a grant.
- Detector:
  - PAT_W-bit window plus a history counter of bits since word start or since the last match.
  - A match is flagged when history ≥ PAT_W and window == PATTERN.
  - On a match: `detector` goes high the next cycle, `match_cnt` increments, and history clears to 0 (non-overlapping).
  - Detector state never carries from one word to the next.
- `match_cnt` includes a match completed by the final bit; it saturates at 2^CNT_W−1 (unreachable with default parameters).
- `req` deasserted without a grant has no effect; `gnt` is never asserted outside IDLE.

## Timing
- Reset values: `gnt`=0, `busy`=0, `detector`=0, `done`=0, `done_id`=0, `match_cnt`=0; FSM=IDLE; pointer=1.
- Reset asserted mid-word aborts the word immediately: no `done` is produced and the word is not re-served.
- Cycle numbering, with the `gnt` cycle as cycle 0:
  - Bit k (k=1..WIDTH) is shifted on the edge ending cycle k−1.
  - `detector` for bit k is visible in cycle k.
  - `done` is high in cycle WIDTH+1.
  - The earliest next `gnt` is cycle WIDTH+2.
- Throughput is one word per WIDTH+2 cycles (10 cycles for default parameters).
- `busy` is high for cycles 1..WIDTH+1.

## Configuration
- `SEQ_ARB_OVERLAP_EN` defined: overlapping detection.
  - History is not cleared on a match; it only saturates at PAT_W.
  - Every window equal to PATTERN after at least PAT_W bits counts.
- Not defined: non-overlapping detection as described under Operation (default).

## Test plan
- Reset: assert `rst` with `req`=2'b11 → all outputs 0, no `gnt`; after release, `gnt`=2'b01 on the first IDLE cycle.
- `req`=01, `data0`=8'b1001_1001 → `gnt[0]` in cycle 0; `detector` high in cycles 4 and 8; `done` in cycle 9 with `done_id`=0 and `match_cnt`=2.
- `req`=10, `data1`=8'b1001_0010:
  - without `SEQ_ARB_OVERLAP_EN` → `match_cnt`=1 (one `detector` pulse, cycle 4);
  - with it → `match_cnt`=2 (`detector` in cycles 4 and 7).
- `req`=11 held continuously → `gnt` alternates 01, 10, 01 in cycles 0, 10, 20; `done_id` alternates 0, 1, 0.
- `rst` pulsed during cycle 4 of a word → `busy` and `detector` drop immediately; no `done`; with `req`=11 afterwards, requester 0 is granted first.
- `data0`=8'h00, then 8'hFF → `match_cnt`=0 for both words and `detector` never high.
